// File: rtl/scarv_cop_wback.sv
// Writeback stage of the SCARV coprocessor: holds the CPR file, commits
// byte-masked results from execute and hands a completion response to the host CPU.
module scarv_cop_wback #(
  parameter int NREGS = 16
) (
  input  logic        g_clk,
  input  logic        g_reset,

  input  logic        wb_ivalid,
  output logic        wb_iready,
  input  logic [3:0]  wb_rd,
  input  logic [3:0]  wb_ben,
  input  logic [31:0] wb_wdata,
  input  logic [2:0]  wb_status,

  input  logic [3:0]  crs1_addr,
  input  logic [3:0]  crs2_addr,
  input  logic [3:0]  crs3_addr,
  output logic [31:0] crs1_rdata,
  output logic [31:0] crs2_rdata,
  output logic [31:0] crs3_rdata,

  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ack,
  output logic [2:0]  cpu_rsp_status,

  output logic [31:0] wb_retired
);

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic [31:0] cpr [NREGS];

  // A pending response may be replaced in the same cycle the host acks it,
  // which keeps back-to-back results flowing at one per cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    wb_iready = 1'b0;
    case (state)
      IDLE: begin
        wb_iready = 1'b1;
        if (wb_ivalid) state_nxt = RSP;
      end
      RSP: begin
        wb_iready = cpu_rsp_ack;
        if (cpu_rsp_ack && !wb_ivalid) state_nxt = IDLE;
      end
    endcase
  end

  assign accept        = wb_ivalid && wb_iready;
  assign cpu_rsp_valid = (state == RSP);

  always_ff @(posedge g_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before this edge.
    if (g_reset) begin
      state          <= IDLE;
      cpu_rsp_status <= '0;
      wb_retired     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cpu_rsp_status <= wb_status;
        wb_retired     <= wb_retired + 32'd1;
      end
    end
  end

  // Destinations at or above NREGS match no register, so such results retire
  // without touching the file.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      // NOTE: this register file must read zero after reset, so every entry
      // is cleared explicitly; it cannot map onto a reset-less RAM macro.
      for (int i = 0; i < NREGS; i++) cpr[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NREGS; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_rd == 4'(i) && wb_ben[b]) cpr[i][8*b +: 8] <= wb_wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads see the pre-edge contents; unimplemented indices read as zero.
  always_comb begin
    crs1_rdata = '0;
    crs2_rdata = '0;
    crs3_rdata = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (crs1_addr == 4'(i)) crs1_rdata = cpr[i];
      if (crs2_addr == 4'(i)) crs2_rdata = cpr[i];
      if (crs3_addr == 4'(i)) crs3_rdata = cpr[i];
    end
  end

endmodule

// File: tb/tb_scarv_cop_wback.sv
// Bench for scarv_cop_wback: directed scenarios then random traffic, checked
// against a transaction-level model of the register file and response slot.
`timescale 1ns/1ps
module tb_scarv_cop_wback;

  localparam int NS = 12;

  logic        g_clk;
  logic        g_reset;
  logic        wb_ivalid;
  logic [3:0]  wb_rd;
  logic [3:0]  wb_ben;
  logic [31:0] wb_wdata;
  logic [2:0]  wb_status;
  logic [3:0]  crs1_addr, crs2_addr, crs3_addr;
  logic        cpu_rsp_ack;

  logic        wb_iready, cpu_rsp_valid;
  logic [2:0]  cpu_rsp_status;
  logic [31:0] crs1_rdata, crs2_rdata, crs3_rdata, wb_retired;

  logic        s_iready, s_valid;
  logic [2:0]  s_status;
  logic [31:0] s_crs1, s_crs2, s_crs3, s_retired;

  scarv_cop_wback u_dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .wb_ivalid(wb_ivalid), .wb_iready(wb_iready), .wb_rd(wb_rd), .wb_ben(wb_ben),
    .wb_wdata(wb_wdata), .wb_status(wb_status),
    .crs1_addr(crs1_addr), .crs2_addr(crs2_addr), .crs3_addr(crs3_addr),
    .crs1_rdata(crs1_rdata), .crs2_rdata(crs2_rdata), .crs3_rdata(crs3_rdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ack(cpu_rsp_ack),
    .cpu_rsp_status(cpu_rsp_status), .wb_retired(wb_retired)
  );

  // Smaller file: destinations 12..15 must retire without writing.
  scarv_cop_wback #(.NREGS(NS)) u_small (
    .g_clk(g_clk), .g_reset(g_reset),
    .wb_ivalid(wb_ivalid), .wb_iready(s_iready), .wb_rd(wb_rd), .wb_ben(wb_ben),
    .wb_wdata(wb_wdata), .wb_status(wb_status),
    .crs1_addr(crs1_addr), .crs2_addr(crs2_addr), .crs3_addr(crs3_addr),
    .crs1_rdata(s_crs1), .crs2_rdata(s_crs2), .crs3_rdata(s_crs3),
    .cpu_rsp_valid(s_valid), .cpu_rsp_ack(cpu_rsp_ack),
    .cpu_rsp_status(s_status), .wb_retired(s_retired)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Reference model: register contents, one pending-response slot, counter.
  logic [31:0] m_cpr   [16];
  logic [31:0] m_small [16];
  bit          m_pend;
  logic [2:0]  m_status;
  logic [31:0] m_cnt;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] rd, input logic [3:0] ben,
                        input logic [31:0] d, input logic [2:0] st, input logic ack);
    wb_ivalid   = v;
    wb_rd       = rd;
    wb_ben      = ben;
    wb_wdata    = d;
    wb_status   = st;
    cpu_rsp_ack = ack;
  endtask

  // Called at a falling edge with inputs set: checks combinational outputs,
  // advances the model at the rising edge, checks registered outputs after it.
  task automatic step();
    bit rdy;
    crs1_addr = 4'($urandom);
    crs2_addr = 4'($urandom);
    crs3_addr = 4'($urandom);
    #1;
    rdy = !m_pend || cpu_rsp_ack;
    check("iready", {31'd0, wb_iready}, {31'd0, rdy});
    check("crs1", crs1_rdata, m_cpr[crs1_addr]);
    check("crs2", crs2_rdata, m_cpr[crs2_addr]);
    check("crs3", crs3_rdata, m_cpr[crs3_addr]);
    if (int'(crs1_addr) < NS) check("small_crs1", s_crs1, m_small[crs1_addr]);
    @(posedge g_clk);
    if (g_reset) begin
      for (int i = 0; i < 16; i++) begin
        m_cpr[i]   = '0;
        m_small[i] = '0;
      end
      m_pend   = 0;
      m_status = '0;
      m_cnt    = '0;
    end else if (wb_ivalid && rdy) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_ben[b]) begin
          m_cpr[wb_rd][8*b +: 8] = wb_wdata[8*b +: 8];
          if (int'(wb_rd) < NS) m_small[wb_rd][8*b +: 8] = wb_wdata[8*b +: 8];
        end
      end
      m_status = wb_status;
      m_pend   = 1;
      m_cnt    = m_cnt + 1;
    end else if (m_pend && cpu_rsp_ack) begin
      m_pend = 0;
    end
    @(negedge g_clk);
    check("rsp_valid", {31'd0, cpu_rsp_valid}, {31'd0, m_pend});
    check("rsp_status", {29'd0, cpu_rsp_status}, {29'd0, m_status});
    check("retired", wb_retired, m_cnt);
    check("small_valid", {31'd0, s_valid}, {31'd0, m_pend});
    check("small_retired", s_retired, m_cnt);
  endtask

  // Walks all 16 addresses with inputs idle; nothing changes state meanwhile.
  task automatic read_all(input string tag);
    set_in(0, 4'd0, 4'd0, 32'd0, 3'd0, 0);
    for (int i = 0; i < 16; i++) begin
      crs1_addr = 4'(i);
      crs2_addr = 4'(15 - i);
      crs3_addr = 4'((i + 5) % 16);
      #2;
      check(tag, crs1_rdata, m_cpr[i]);
      check(tag, crs2_rdata, m_cpr[15 - i]);
      check(tag, crs3_rdata, m_cpr[(i + 5) % 16]);
    end
    @(negedge g_clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt0;
    g_reset = 1'b1;
    set_in(0, 4'd0, 4'd0, 32'd0, 3'd0, 0);
    crs1_addr = '0; crs2_addr = '0; crs3_addr = '0;
    for (int i = 0; i < 16; i++) begin
      m_cpr[i] = 'x; m_small[i] = 'x;
    end
    m_pend = 0; m_status = '0; m_cnt = '0;
    @(negedge g_clk);

    // Reset, then everything reads zero and ready is up immediately.
    step();
    step();
    g_reset = 1'b0;
    read_all("reset_cpr");
    check("reset_retired", wb_retired, 32'd0);
    check("reset_valid", {31'd0, cpu_rsp_valid}, 32'd0);
    check("reset_iready", {31'd0, wb_iready}, 32'd1);

    // Full write then a byte-masked overwrite of CPR3.
    set_in(1, 4'd3, 4'hF, 32'hDEADBEEF, 3'd1, 0); step();
    set_in(1, 4'd3, 4'b0101, 32'h11223344, 3'd2, 1); step();
    set_in(0, 4'd0, 4'h0, 32'd0, 3'd0, 1); step();
    crs1_addr = 4'd3;
    #1;
    check("cpr3_merge", crs1_rdata, 32'hDE22BE44);
    check("retired_two", wb_retired, 32'd2);
    @(negedge g_clk);

    // Zero byte-enable still retires and responds.
    set_in(1, 4'd7, 4'h0, 32'hFFFFFFFF, 3'd3, 0); step();
    check("ben0_valid", {31'd0, cpu_rsp_valid}, 32'd1);
    check("ben0_retired", wb_retired, 32'd3);
    read_all("ben0_cpr");

    // Backpressure: no ack for 5 cycles, then an accept on the ack cycle.
    set_in(1, 4'd9, 4'hF, 32'hCAFEF00D, 3'd4, 0);
    repeat (5) begin
      step();
      check("stall_iready", {31'd0, wb_iready}, 32'd0);
      check("stall_status", {29'd0, cpu_rsp_status}, 32'd3);
    end
    cpu_rsp_ack = 1'b1; step();
    check("ack_accept_valid", {31'd0, cpu_rsp_valid}, 32'd1);
    check("ack_accept_status", {29'd0, cpu_rsp_status}, 32'd4);
    check("ack_accept_retired", wb_retired, 32'd4);
    set_in(0, 4'd0, 4'h0, 32'd0, 3'd0, 1); step();
    check("drain_valid", {31'd0, cpu_rsp_valid}, 32'd0);

    // Ten back-to-back results with ack held high.
    cnt0 = wb_retired;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 4'($urandom), 4'($urandom), $urandom, 3'($urandom), 1);
      step();
    end
    check("burst_retired", wb_retired, cnt0 + 32'd10);
    set_in(0, 4'd0, 4'h0, 32'd0, 3'd0, 1); step();

    // Reset during a pending response drops it and blocks the write.
    g_reset = 1'b1; step();
    g_reset = 1'b0;
    set_in(1, 4'd1, 4'hF, 32'h01010101, 3'd5, 0); step();
    g_reset = 1'b1;
    set_in(1, 4'd5, 4'hF, 32'h55555555, 3'd6, 1); step();
    g_reset = 1'b0;
    set_in(0, 4'd0, 4'h0, 32'd0, 3'd0, 0);
    check("rst_valid", {31'd0, cpu_rsp_valid}, 32'd0);
    crs1_addr = 4'd5;
    #1;
    check("rst_cpr5", crs1_rdata, 32'd0);
    check("rst_iready", {31'd0, wb_iready}, 32'd1);
    @(negedge g_clk);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      g_reset = ($urandom_range(0, 63) == 0);
      set_in($urandom_range(0, 3) != 0, 4'($urandom),
             ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
             $urandom, 3'($urandom), 1'($urandom));
      step();
    end
    g_reset = 1'b0;
    read_all("final_cpr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
